// File: rtl/dffc_share_arbiter.sv
// dffc_share_arbiter: round-robin arbiter sharing one clear/preset register between four requesters.
// Define REGBANK_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module dffc_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [3:0]           req,
    input  logic [7:0]           op,
    input  logic [4*WIDTH-1:0]   din,
    output logic [3:0]           gnt,
    output logic [3:0]           ack,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qnot
);
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
    state_t state;
    logic [1:0] ptr, win, cmd;
    logic [WIDTH-1:0] lane, q_next;

    // Scan downward so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    assign cmd    = op[2*owner +: 2];
    assign lane   = din[WIDTH*owner +: WIDTH];
    assign q_next = cmd == 2'b00 ? lane : cmd == 2'b01 ? '0 : cmd == 2'b10 ? '1 : q;
    assign busy   = state != IDLE;
    assign qnot   = ~q;

`ifdef REGBANK_FIXED_PRIO_EN
    assign ptr = 2'd0;
`else
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            ptr <= 2'd0;
        else if (state == ACK)
            ptr <= owner + 2'd1;
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            owner <= '0;
            q     <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= GRANT;
                    gnt   <= 4'b0001 << win;
                    owner <= win;
                end
                GRANT: if (req[owner]) begin
                    state <= ACK;
                    q     <= q_next;
                    ack   <= 4'b0001 << owner;
                end else begin
                    state <= IDLE;
                    gnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ack   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/dffc_share_arbiter.md
# dffc_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit storage register between four requesters. The register is built from clear/preset D flip-flop cells. Each requester posts a load, clear, preset or hold command. The arbiter grants one requester at a time, applies the command on a fixed three-cycle schedule and returns a one-cycle acknowledge. It sits between independent control sources and the single DFFC-based register they must not drive concurrently.

## Interface
- WIDTH, 4, bit width of the shared register and of each requester's data lane
- clk  input  1  system clock, rising-edge active
- clr  input  1  asynchronous reset, active-low; clears the whole block immediately
- req  input  4  per-requester request; bit i belongs to requester i
- op  input  8  per-requester command; op[2i+1:2i] is requester i's command: 00 load, 01 clear, 10 preset, 11 hold
- din  input  4*WIDTH  per-requester load data; din[WIDTH*i +: WIDTH] is requester i's lane
- gnt  output  4  one-hot grant, registered
- ack  output  4  one-hot completion pulse, exactly one clk cycle
- busy  output  1  high while a transaction is in progress (state not IDLE)
- owner  output  2  index of the most recently granted requester
- q  output  WIDTH  shared register value
- qnot  output  WIDTH  always equal to ~q

## Operation
- Clock and reset: one clock domain. clr is asynchronous, active-low.
- State machine: IDLE, GRANT, ACK.
- IDLE → GRANT:
  - On a clk edge with any req bit high, select the winner w.
  - Selection is round-robin: search starts at rotating pointer ptr and proceeds ptr, ptr+1, … modulo 4.
  - On that edge gnt[w]=1 and owner=w.
- GRANT → ACK, when req[w] is still high at the next edge, the command is applied to q on that edge:
  - 00: q=din lane w
  - 01: q=0
  - 10: q=all ones
  - 11: q unchanged
  - On that edge ack[w]=1 and gnt[w] stays 1.
- GRANT → IDLE (abort), when req[w] is low at the GRANT edge:
  - q is unchanged, gnt drops, no ack is issued.
  - ptr is not advanced.
- ACK → IDLE:
  - On the next edge gnt and ack return to 0.
  - ptr=(w+1) mod 4.
- Sampling: op and din are sampled only at the GRANT edge. Requesters hold them stable from req assertion until ack.
- Re-request: a requester may keep req high after ack. It is then arbitrated again behind the other active requesters.
- Non-winning requests: they wait and are never dropped.
- Pointer wrap: after a grant to requester 3, ptr returns to 0.

## Timing
- Reset value of every output:
  - gnt=0, ack=0, busy=0, owner=0
  - q=0, qnot=all ones
  - internal ptr=0, state IDLE
- Latency: req high before edge E0 gives gnt after E0, q updated and ack high after E0+1, gnt/ack low after E0+2.
- Throughput: one command per 3 cycles. IDLE lasts at least one cycle between transactions.
- busy is high for exactly the GRANT and ACK cycles.
- Simultaneous requests: only the round-robin winner is served; the others are served in pointer order in subsequent transactions.
- Reset mid-transaction: clr low in GRANT or ACK forces the reset values immediately. A partially granted command is lost and no ack is issued.
- qnot is combinational from q; it never differs from ~q, including during reset.

## Configuration
- REGBANK_FIXED_PRIO_EN defined: fixed priority, requester 0 highest and requester 3 lowest. ptr is ignored and never updated.
- REGBANK_FIXED_PRIO_EN undefined (default): round-robin as specified above.
- The timing and state machine are identical in both builds.

## Test plan
- Reset: clr=0 with arbitrary inputs → q=0, qnot=1111, gnt=0, ack=0, busy=0, owner=0; after clr=1 with req=0 all outputs stay unchanged.
- Single load: WIDTH=4, req=0001, op lane0=00, din lane0=1010 → gnt=0001 after E0, q=1010 and ack=0001 after E0+1, idle after E0+2.
- Clear/preset/hold: requester 2 in sequence with preset → q=1111, then clear → q=0000, then hold → q=0000 with ack=0100 each time.
- Round-robin fairness, default build: req=1111 held continuously → grants issued in order 0,1,2,3,0 with owner tracking; with REGBANK_FIXED_PRIO_EN → every grant goes to requester 0.
- Abort: requester 1 drops req during GRANT → no ack, q unchanged, next grant still starts search at the same ptr.
- Reset mid-operation: clr pulsed low during ACK of a load of 0110 → ack cleared immediately, q=0000, ptr=0, next grant with req=1000 goes to requester 3.
